// File: rtl/thread_lsu_if.sv
// Data-memory valid/ready channel between a thread LSU (master) and memory (slave).
interface thread_lsu_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/thread_lsu.sv
// Per-thread load/store unit: issues one read or write per memory instruction
// on the data-memory channel and keeps the last loaded value for the register file.
module thread_lsu #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  thread_lsu_if.master         dmem,
  output logic [1:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out
);

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  lsu_state_t           state_r, state_s;
  logic                 op_read_r, op_read_s;
  logic                 read_valid_r, read_valid_s;
  logic [ADDR_BITS-1:0] read_address_r, read_address_s;
  logic                 write_valid_r, write_valid_s;
  logic [ADDR_BITS-1:0] write_address_r, write_address_s;
  logic [DATA_BITS-1:0] write_data_r, write_data_s;
  logic [DATA_BITS-1:0] lsu_out_r, lsu_out_s;
  logic [ADDR_BITS-1:0] addr_s;

  // Address comes from the low bits of rs, zero-extended when the bus is wider.
  generate
    if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
      assign addr_s = rs[ADDR_BITS-1:0];
    end else begin : g_addr_ext
      assign addr_s = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
    end
  endgenerate

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_s         = state_r;
    op_read_s       = op_read_r;
    read_valid_s    = read_valid_r;
    read_address_s  = read_address_r;
    write_valid_s   = write_valid_r;
    write_address_s = write_address_r;
    write_data_s    = write_data_r;
    lsu_out_s       = lsu_out_r;
    case (state_r)
      LSU_IDLE: begin
        if (enable && (core_state == CORE_REQUEST) &&
            (decoded_mem_read_enable || decoded_mem_write_enable)) begin
          state_s   = LSU_REQUESTING;
          op_read_s = decoded_mem_read_enable;
          // Reads win when both enables are set; operands are captured here only.
          if (decoded_mem_read_enable) begin
            read_valid_s   = 1'b1;
            read_address_s = addr_s;
          end else begin
            write_valid_s   = 1'b1;
            write_address_s = addr_s;
            write_data_s    = rt;
          end
        end else begin
          state_s = LSU_IDLE;
        end
      end
      LSU_REQUESTING: begin
        state_s = LSU_WAITING;
      end
      LSU_WAITING: begin
        // Only the ready of the channel in use can complete the transaction.
        if (op_read_r) begin
          if (dmem.mem_read_ready) begin
            read_valid_s = 1'b0;
            lsu_out_s    = dmem.mem_read_data;
            state_s      = LSU_DONE;
          end else begin
            state_s = LSU_WAITING;
          end
        end else begin
          if (dmem.mem_write_ready) begin
            write_valid_s = 1'b0;
            state_s       = LSU_DONE;
          end else begin
            state_s = LSU_WAITING;
          end
        end
      end
      LSU_DONE: begin
        read_valid_s  = 1'b0;
        write_valid_s = 1'b0;
        if (core_state == CORE_UPDATE) begin
          state_s = LSU_IDLE;
        end else begin
          state_s = LSU_DONE;
        end
      end
      default: begin
        state_s       = LSU_IDLE;
        read_valid_s  = 1'b0;
        write_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= LSU_IDLE;
      op_read_r       <= 1'b0;
      read_valid_r    <= 1'b0;
      read_address_r  <= {ADDR_BITS{1'b0}};
      write_valid_r   <= 1'b0;
      write_address_r <= {ADDR_BITS{1'b0}};
      write_data_r    <= {DATA_BITS{1'b0}};
      lsu_out_r       <= {DATA_BITS{1'b0}};
    end else begin
      state_r         <= state_s;
      op_read_r       <= op_read_s;
      read_valid_r    <= read_valid_s;
      read_address_r  <= read_address_s;
      write_valid_r   <= write_valid_s;
      write_address_r <= write_address_s;
      write_data_r    <= write_data_s;
      lsu_out_r       <= lsu_out_s;
    end
  end

  assign dmem.mem_read_valid    = read_valid_r;
  assign dmem.mem_read_address  = read_address_r;
  assign dmem.mem_write_valid   = write_valid_r;
  assign dmem.mem_write_address = write_address_r;
  assign dmem.mem_write_data    = write_data_r;
  assign lsu_state              = state_r;
  assign lsu_out                = lsu_out_r;

endmodule

// File: tb/tb_thread_lsu.sv
// Directed self-checking bench for thread_lsu.
module tb_thread_lsu;
  logic       clk;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] rs;
  logic [7:0] rt;
  logic [1:0] lsu_state;
  logic [7:0] lsu_out;

  int checks;
  int errors;

  thread_lsu_if #(.DATA_BITS(8), .ADDR_BITS(8)) dmem ();

  thread_lsu #(.DATA_BITS(8), .ADDR_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs                       (rs),
    .rt                       (rt),
    .dmem                     (dmem),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rv"}, {15'd0, dmem.mem_read_valid}, 16'd0);
    check_eq({tag, "_wv"}, {15'd0, dmem.mem_write_valid}, 16'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    core_state = 3'b000;
    rd_en = 1'b0;
    wr_en = 1'b0;
    rs = 8'h00;
    rt = 8'h00;
    dmem.mem_read_ready = 1'b0;
    dmem.mem_read_data = 8'h00;
    dmem.mem_write_ready = 1'b0;

    // Reset state
    #2;
    check_eq("rst_state", {14'd0, lsu_state}, 16'h0000);
    check_idle_outputs("rst");
    check_eq("rst_lsu_out", {8'd0, lsu_out}, 16'h0000);
    check_eq("rst_raddr", {8'd0, dmem.mem_read_address}, 16'h0000);
    check_eq("rst_waddr", {8'd0, dmem.mem_write_address}, 16'h0000);
    check_eq("rst_wdata", {8'd0, dmem.mem_write_data}, 16'h0000);
    step();
    reset = 1'b1;
    step();

    // LDR rs=0x3C, ready arrives after two WAITING cycles, rs changes after REQUEST
    enable = 1'b1; core_state = 3'b011; rd_en = 1'b1; rs = 8'h3C;
    step();
    check_eq("ldr_s1", {14'd0, lsu_state}, 16'h0001);
    check_eq("ldr_rv1", {15'd0, dmem.mem_read_valid}, 16'd1);
    check_eq("ldr_addr1", {8'd0, dmem.mem_read_address}, 16'h003C);
    check_eq("ldr_wv1", {15'd0, dmem.mem_write_valid}, 16'd0);
    core_state = 3'b100; rs = 8'hFF; rd_en = 1'b0;
    step();
    check_eq("ldr_s2", {14'd0, lsu_state}, 16'h0002);
    check_eq("ldr_addr2", {8'd0, dmem.mem_read_address}, 16'h003C);
    step();
    check_eq("ldr_s3", {14'd0, lsu_state}, 16'h0002);
    check_eq("ldr_rv3", {15'd0, dmem.mem_read_valid}, 16'd1);
    check_eq("ldr_addr3", {8'd0, dmem.mem_read_address}, 16'h003C);
    dmem.mem_read_ready = 1'b1; dmem.mem_read_data = 8'hA5;
    step();
    check_eq("ldr_s4", {14'd0, lsu_state}, 16'h0003);
    check_eq("ldr_rv4", {15'd0, dmem.mem_read_valid}, 16'd0);
    check_eq("ldr_out", {8'd0, lsu_out}, 16'h00A5);
    dmem.mem_read_ready = 1'b0; dmem.mem_read_data = 8'h00;

    // DONE hold under EXECUTE, then UPDATE returns to IDLE
    core_state = 3'b101;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_state", {14'd0, lsu_state}, 16'h0003);
      check_idle_outputs("hold");
    end
    core_state = 3'b110;
    step();
    check_eq("upd_state", {14'd0, lsu_state}, 16'h0000);
    check_eq("upd_out", {8'd0, lsu_out}, 16'h00A5);

    // STR rs=0x10 rt=0x7E with ready already high
    core_state = 3'b011; wr_en = 1'b1; rs = 8'h10; rt = 8'h7E;
    dmem.mem_write_ready = 1'b1;
    step();
    check_eq("str_s1", {14'd0, lsu_state}, 16'h0001);
    check_eq("str_wv1", {15'd0, dmem.mem_write_valid}, 16'd1);
    check_eq("str_addr1", {8'd0, dmem.mem_write_address}, 16'h0010);
    check_eq("str_data1", {8'd0, dmem.mem_write_data}, 16'h007E);
    check_eq("str_rv1", {15'd0, dmem.mem_read_valid}, 16'd0);
    core_state = 3'b100; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
    step();
    check_eq("str_s2", {14'd0, lsu_state}, 16'h0002);
    check_eq("str_wv2", {15'd0, dmem.mem_write_valid}, 16'd1);
    check_eq("str_addr2", {8'd0, dmem.mem_write_address}, 16'h0010);
    check_eq("str_data2", {8'd0, dmem.mem_write_data}, 16'h007E);
    step();
    check_eq("str_s3", {14'd0, lsu_state}, 16'h0003);
    check_idle_outputs("str3");
    check_eq("str_out", {8'd0, lsu_out}, 16'h00A5);
    dmem.mem_write_ready = 1'b0;
    core_state = 3'b110;
    step();
    check_eq("str_upd", {14'd0, lsu_state}, 16'h0000);

    // Both enables: read wins; write ready is ignored while waiting on a read
    core_state = 3'b011; rd_en = 1'b1; wr_en = 1'b1; rs = 8'h05; rt = 8'h99;
    step();
    check_eq("both_s1", {14'd0, lsu_state}, 16'h0001);
    check_eq("both_rv1", {15'd0, dmem.mem_read_valid}, 16'd1);
    check_eq("both_wv1", {15'd0, dmem.mem_write_valid}, 16'd0);
    check_eq("both_addr", {8'd0, dmem.mem_read_address}, 16'h0005);
    core_state = 3'b100; rd_en = 1'b0; wr_en = 1'b0;
    dmem.mem_write_ready = 1'b1;
    step();
    step();
    check_eq("both_s3", {14'd0, lsu_state}, 16'h0002);
    check_eq("both_wv3", {15'd0, dmem.mem_write_valid}, 16'd0);
    dmem.mem_write_ready = 1'b0;
    dmem.mem_read_ready = 1'b1; dmem.mem_read_data = 8'h3C;
    step();
    check_eq("both_s4", {14'd0, lsu_state}, 16'h0003);
    check_eq("both_out", {8'd0, lsu_out}, 16'h003C);
    dmem.mem_read_ready = 1'b0;
    core_state = 3'b110;
    step();
    check_eq("both_upd", {14'd0, lsu_state}, 16'h0000);

    // enable low with LDR during REQUEST: no request
    enable = 1'b0; core_state = 3'b011; rd_en = 1'b1; rs = 8'h44;
    step();
    check_eq("dis_state", {14'd0, lsu_state}, 16'h0000);
    check_idle_outputs("dis");
    // Non-memory instruction during REQUEST: no request
    enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    step();
    check_eq("add_state", {14'd0, lsu_state}, 16'h0000);
    check_idle_outputs("add");

    // Asynchronous reset while WAITING on a read
    rd_en = 1'b1; rs = 8'h22;
    step();
    core_state = 3'b100; rd_en = 1'b0;
    step();
    check_eq("ar_pre", {14'd0, lsu_state}, 16'h0002);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_state", {14'd0, lsu_state}, 16'h0000);
    check_eq("ar_rv", {15'd0, dmem.mem_read_valid}, 16'd0);
    check_eq("ar_out", {8'd0, lsu_out}, 16'h0000);
    step();
    reset = 1'b1;
    core_state = 3'b000;
    step();
    check_eq("ar_after", {14'd0, lsu_state}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
